// File: rtl/fifo_burst_reader.sv
// rtl/fifo_burst_reader.sv - burst read master: pops L FIFO words into a 2-entry skid buffer and streams them out.
// Optional per-word last flag on out_last when FIFO_BURST_READER_LAST_EN is defined.
module fifo_burst_reader #(
    parameter int N     = 32,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             fifo_empty,
    input  logic [N-1:0]     fifo_rdata,
    output logic             fifo_re,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_data,
`ifdef FIFO_BURST_READER_LAST_EN
    output logic             out_last,
`endif
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [LEN_W-1:0] REM_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

    logic [1:0]       state;
    logic [LEN_W-1:0] rem;
    logic [1:0]       bcnt;
    logic [1:0]       bcnt_nxt;
    logic [N-1:0]     data0;
    logic [N-1:0]     data1;
    logic             accept;

    assign cmd_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign out_valid = (bcnt != 2'd0);
    assign out_data  = out_valid ? data0 : '0;
    assign accept    = out_valid && out_ready;

    // Pop decision looks only at registered bcnt, so out_ready never reaches fifo_re.
    assign fifo_re = (state == S_FETCH) && !fifo_empty && (bcnt != 2'd2) && (rem != '0);

    always_comb begin
        bcnt_nxt = bcnt;
        if (fifo_re && !accept)
            bcnt_nxt = bcnt + 2'd1;
        else if (!fifo_re && accept)
            bcnt_nxt = bcnt - 2'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            rem   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        rem   <= cmd_len;
                        state <= (cmd_len != '0) ? S_FETCH : S_FLUSH;
                    end
                end
                S_FETCH: begin
                    if (fifo_re) begin
                        rem <= rem - REM_ONE;
                        if (rem == REM_ONE)
                            state <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    if (bcnt_nxt == 2'd0)
                        state <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Skid buffer: data0 is the head; a simultaneous pop and accept can only occur with bcnt==1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcnt  <= 2'd0;
            data0 <= '0;
            data1 <= '0;
        end else begin
            bcnt <= bcnt_nxt;
            case ({fifo_re, accept})
                2'b10: begin
                    if (bcnt == 2'd0)
                        data0 <= fifo_rdata;
                    else
                        data1 <= fifo_rdata;
                end
                2'b01: data0 <= data1;
                2'b11: data0 <= fifo_rdata;
                default: ;
            endcase
        end
    end

`ifdef FIFO_BURST_READER_LAST_EN
    logic last0;
    logic last1;
    logic pop_last;

    assign pop_last = (rem == REM_ONE);
    assign out_last = out_valid && last0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last0 <= 1'b0;
            last1 <= 1'b0;
        end else begin
            case ({fifo_re, accept})
                2'b10: begin
                    if (bcnt == 2'd0)
                        last0 <= pop_last;
                    else
                        last1 <= pop_last;
                end
                2'b01: last0 <= last1;
                2'b11: last0 <= pop_last;
                default: ;
            endcase
        end
    end
`endif

endmodule
